// File: rtl/proc_pkg.sv
// rtl/proc_pkg.sv - shared types and instruction-field constants for the sequencer and processor
package proc_pkg;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_HALT,
    S_ERROR
  } seq_state_t;

  localparam logic [1:0] OP_MV   = 2'b00;
  localparam logic [1:0] OP_ADD  = 2'b01;
  localparam logic [1:0] OP_SUB  = 2'b10;
  localparam logic [1:0] OP_MULT = 2'b11;

  // Instruction layout: II[15:14] opcode, M[13] immediate select, rX[12], rY[0] or imm[11:0]
  localparam int II_HI  = 15;
  localparam int II_LO  = 14;
  localparam int M_BIT  = 13;
  localparam int RX_BIT = 12;
  localparam int RY_BIT = 0;
  localparam int IMM_HI = 11;
  localparam int IMM_LO = 0;

endpackage

// File: rtl/prog_mem.sv
// rtl/prog_mem.sv - program memory, one write port and one asynchronous read port, no reset
module prog_mem #(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               we,
  input  logic [ADDR_W-1:0]  waddr,
  input  logic [INSTR_W-1:0] wdata,
  input  logic [ADDR_W-1:0]  raddr,
  output logic [INSTR_W-1:0] rdata
);

  logic [INSTR_W-1:0] mem [0:(2**ADDR_W)-1];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/instr_sequencer.sv
// rtl/instr_sequencer.sv - issues a stored program to the processor one instruction at a time
module instr_sequencer
  import proc_pkg::*;
#(
  parameter int ADDR_W  = 4,
  parameter int INSTR_W = 16,
  parameter int TIMEOUT = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start,
  input  logic               abort,
  input  logic [ADDR_W:0]    prog_len,
  input  logic               prog_we,
  input  logic [ADDR_W-1:0]  prog_waddr,
  input  logic [INSTR_W-1:0] prog_wdata,
  input  logic               done_in,
  output logic [INSTR_W-1:0] instr,
  output logic               run,
  output logic [ADDR_W-1:0]  pc,
  output logic [ADDR_W:0]    retired,
  output logic               busy,
  output logic               halted,
  output logic               err
);

  localparam int WD_W = $clog2(TIMEOUT + 1);

  seq_state_t         state;
  logic [ADDR_W:0]    len;
  logic [WD_W-1:0]    wd;
  logic               idle_like;
  logic [ADDR_W-1:0]  raddr;
  logic [INSTR_W-1:0] rdata;

  assign idle_like = (state == S_IDLE) || (state == S_HALT) || (state == S_ERROR);
  // Outside WAIT the only fetch needed is address 0 for a start.
  assign raddr = (state == S_WAIT) ? pc + 1'b1 : '0;

  prog_mem #(
    .ADDR_W (ADDR_W),
    .INSTR_W(INSTR_W)
  ) u_mem (
    .clk  (clk),
    .we   (prog_we && idle_like),
    .waddr(prog_waddr),
    .wdata(prog_wdata),
    .raddr(raddr),
    .rdata(rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      instr   <= '0;
      run     <= 1'b0;
      pc      <= '0;
      retired <= '0;
      busy    <= 1'b0;
      halted  <= 1'b0;
      err     <= 1'b0;
      len     <= '0;
      wd      <= '0;
    end else if (abort) begin
      state  <= S_IDLE;
      run    <= 1'b0;
      busy   <= 1'b0;
      halted <= 1'b0;
      err    <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_HALT, S_ERROR: begin
          if (start) begin
            pc      <= '0;
            retired <= '0;
            len     <= prog_len;
            err     <= 1'b0;
            if (prog_len != '0) begin
              state  <= S_ISSUE;
              instr  <= rdata;
              run    <= 1'b1;
              busy   <= 1'b1;
              halted <= 1'b0;
            end else begin
              state  <= S_HALT;
              halted <= 1'b1;
            end
          end
        end
        S_ISSUE: begin
          state <= S_WAIT;
          run   <= 1'b0;
          wd    <= '0;
        end
        S_WAIT: begin
          if (done_in) begin
            retired <= retired + 1'b1;
            if ({1'b0, pc} == len - 1'b1) begin
              state  <= S_HALT;
              busy   <= 1'b0;
              halted <= 1'b1;
            end else begin
              state <= S_ISSUE;
              pc    <= pc + 1'b1;
              instr <= rdata;
              run   <= 1'b1;
            end
          end else if (wd == WD_W'(TIMEOUT - 1)) begin
            state <= S_ERROR;
            busy  <= 1'b0;
            err   <= 1'b1;
          end else begin
            wd <= wd + 1'b1;
          end
        end
        default: begin
          state <= S_IDLE;
          run   <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_sequencer.sv
// tb/tb_instr_sequencer.sv - scoreboard bench for instr_sequencer with a behavioural processor
module tb_instr_sequencer;
  import proc_pkg::*;

  localparam int K_RUN  = 1;
  localparam int K_HALT = 2;
  localparam int K_ERR  = 3;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        start = 1'b0;
  logic        abort = 1'b0;
  logic [4:0]  prog_len = '0;
  logic        prog_we = 1'b0;
  logic [3:0]  prog_waddr = '0;
  logic [15:0] prog_wdata = '0;
  logic        done_in;
  logic [15:0] instr;
  logic        run;
  logic [3:0]  pc;
  logic [4:0]  retired;
  logic        busy, halted, err;

  instr_sequencer #(.ADDR_W(4), .INSTR_W(16), .TIMEOUT(8)) dut (
    .clk(clk), .reset(reset), .start(start), .abort(abort), .prog_len(prog_len),
    .prog_we(prog_we), .prog_waddr(prog_waddr), .prog_wdata(prog_wdata),
    .done_in(done_in), .instr(instr), .run(run), .pc(pc), .retired(retired),
    .busy(busy), .halted(halted), .err(err)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Processor stand-in: mv finishes in its first cycle after run, alu ops in the third
  logic [15:0] r0, r1, ir;
  logic [1:0]  pst = 2'd0;
  logic        tie_low = 1'b0;
  logic [1:0]  fin;
  logic [15:0] opnd, dst;
  assign fin     = (ir[II_HI:II_LO] == OP_MV) ? 2'd1 : 2'd3;
  assign done_in = !tie_low && (pst != 2'd0) && (pst == fin);
  assign opnd    = ir[M_BIT] ? {{4{ir[IMM_HI]}}, ir[IMM_HI:IMM_LO]} : (ir[RY_BIT] ? r1 : r0);
  assign dst     = ir[RX_BIT] ? r1 : r0;

  always @(posedge clk) begin
    if (reset) begin
      pst <= 2'd0; r0 <= '0; r1 <= '0; ir <= '0;
    end else if (pst == 2'd0) begin
      if (run) begin ir <= instr; pst <= 2'd1; end
    end else if (done_in) begin
      logic [15:0] res;
      case (ir[II_HI:II_LO])
        OP_MV:   res = opnd;
        OP_ADD:  res = dst + opnd;
        OP_SUB:  res = dst - opnd;
        default: res = dst * opnd;
      endcase
      if (ir[RX_BIT]) r1 <= res; else r0 <= res;
      pst <= 2'd0;
    end else if (pst != fin) begin
      pst <= pst + 2'd1;
    end
  end

  typedef struct {
    int          kind;
    int          cyc;
    logic [15:0] instr;
    logic [4:0]  retired;
    logic [3:0]  pc;
  } exp_t;
  exp_t q[$];

  int checks = 0;
  int errors = 0;
  int base = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int off, input logic [15:0] ins,
                      input logic [4:0] ret, input logic [3:0] p);
    exp_t e;
    e.kind = kind; e.cyc = base + off; e.instr = ins; e.retired = ret; e.pc = p;
    q.push_back(e);
  endtask

  task automatic pop_cmp(input int kind);
    exp_t e;
    if (q.size() == 0) begin
      chk("unexpected_event_kind", kind, 0);
    end else begin
      e = q.pop_front();
      chk("event_kind", kind, e.kind);
      chk("event_cycle", cyc, e.cyc);
      if (kind == K_RUN) begin
        chk("run_instr", instr, e.instr);
      end else begin
        chk("end_retired", retired, e.retired);
        chk("end_pc", pc, e.pc);
        if (kind == K_ERR) chk("err_instr", instr, e.instr);
      end
    end
  endtask

  logic prev_h = 1'b0, prev_e = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      if (run) pop_cmp(K_RUN);
      if (halted && !prev_h) pop_cmp(K_HALT);
      if (err && !prev_e) pop_cmp(K_ERR);
    end
    prev_h = halted;
    prev_e = err;
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic write_mem(input logic [3:0] a, input logic [15:0] d);
    prog_we = 1'b1; prog_waddr = a; prog_wdata = d;
    tick();
    prog_we = 1'b0;
  endtask

  task automatic do_start(input logic [4:0] len);
    start = 1'b1; prog_len = len;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_end(input int max);
    int n = 0;
    while (!(halted || err) && n < max) begin
      tick();
      n++;
    end
    chk("wait_end_reached", {31'd0, halted || err}, 32'd1);
    tick();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    tick(); tick();
    reset = 1'b0;
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_instr"}, instr, 16'h0);
    chk({tag, "_run"}, run, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_retired"}, retired, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_halted"}, halted, 0);
    chk({tag, "_err"}, err, 0);
  endtask

  initial begin
    tick(); tick();
    reset = 1'b0;
    chk_reset_outputs("reset");

    // Four-instruction program: r0=5, r0+=3, r1=r0, r0*=2
    write_mem(4'd0, 16'h2005);
    write_mem(4'd1, 16'h6003);
    write_mem(4'd2, 16'h1000);
    write_mem(4'd3, 16'hE002);
    base = cyc + 1;
    push(K_RUN, 0, 16'h2005, 0, 0);
    push(K_RUN, 2, 16'h6003, 0, 0);
    push(K_RUN, 6, 16'h1000, 0, 0);
    push(K_RUN, 8, 16'hE002, 0, 0);
    push(K_HALT, 12, 0, 5'd4, 4'd3);
    do_start(5'd4);
    wait_end(40);
    chk("prog4_r0", r0, 16'd16);
    chk("prog4_r1", r1, 16'd8);

    // Single mv with negative immediate, restarted from HALT
    write_mem(4'd0, 16'h2FFF);
    base = cyc + 1;
    push(K_RUN, 0, 16'h2FFF, 0, 0);
    push(K_HALT, 2, 0, 5'd1, 4'd0);
    do_start(5'd1);
    wait_end(20);
    chk("mv_r0_sext", r0, 16'hFFFF);

    // Watchdog: processor never signals done
    pulse_reset();
    tie_low = 1'b1;
    base = cyc + 1;
    push(K_RUN, 0, 16'h2FFF, 0, 0);
    push(K_ERR, 9, 16'h2FFF, 5'd0, 4'd0);
    do_start(5'd1);
    wait_end(30);
    tie_low = 1'b0;
    pulse_reset();

    // Abort in the second WAIT cycle of an add
    write_mem(4'd0, 16'h6003);
    write_mem(4'd1, 16'h2005);
    base = cyc + 1;
    push(K_RUN, 0, 16'h6003, 0, 0);
    do_start(5'd2);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_busy", busy, 0);
    chk("abort_run", run, 0);
    chk("abort_retired", retired, 0);
    chk("abort_halted", halted, 0);
    repeat (6) tick();
    pulse_reset();
    base = cyc + 1;
    push(K_RUN, 0, 16'h6003, 0, 0);
    push(K_RUN, 4, 16'h2005, 0, 0);
    push(K_HALT, 6, 0, 5'd2, 4'd1);
    do_start(5'd2);
    wait_end(30);
    chk("after_abort_r0", r0, 16'd5);

    // Program writes while busy must be dropped
    base = cyc + 1;
    push(K_RUN, 0, 16'h6003, 0, 0);
    push(K_HALT, 4, 0, 5'd1, 4'd0);
    do_start(5'd1);
    prog_we = 1'b1; prog_waddr = 4'd0; prog_wdata = 16'h2001;
    repeat (4) tick();
    prog_we = 1'b0;
    wait_end(20);
    base = cyc + 1;
    push(K_RUN, 0, 16'h6003, 0, 0);
    push(K_HALT, 4, 0, 5'd1, 4'd0);
    do_start(5'd1);
    wait_end(20);
    write_mem(4'd0, 16'h2001);
    base = cyc + 1;
    push(K_RUN, 0, 16'h2001, 0, 0);
    push(K_HALT, 2, 0, 5'd1, 4'd0);
    do_start(5'd1);
    wait_end(20);
    chk("halt_write_r0", r0, 16'd1);

    // Write and start on the same edge: the fetch sees the old word
    prog_we = 1'b1; prog_waddr = 4'd0; prog_wdata = 16'h2005;
    base = cyc + 1;
    push(K_RUN, 0, 16'h2001, 0, 0);
    push(K_HALT, 2, 0, 5'd1, 4'd0);
    do_start(5'd1);
    prog_we = 1'b0;
    wait_end(20);
    base = cyc + 1;
    push(K_RUN, 0, 16'h2005, 0, 0);
    push(K_HALT, 2, 0, 5'd1, 4'd0);
    do_start(5'd1);
    wait_end(20);
    chk("same_edge_r0", r0, 16'd5);

    // Zero-length program goes straight to HALT
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk("abort_from_halt", halted, 0);
    base = cyc + 1;
    push(K_HALT, 0, 0, 5'd0, 4'd0);
    do_start(5'd0);
    tick(); tick();
    chk("len0_halted", halted, 1);

    // Reset in the middle of WAIT
    write_mem(4'd0, 16'h6003);
    base = cyc + 1;
    push(K_RUN, 0, 16'h6003, 0, 0);
    do_start(5'd1);
    tick();
    reset = 1'b1;
    tick();
    chk_reset_outputs("midwait_reset");
    reset = 1'b0;
    repeat (4) tick();

    chk("scoreboard_empty", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/instr_sequencer.md
Name: instr_sequencer

Overview:
- Program sequencer for the two-register mv/add/sub/mult processor.
- Holds a small program memory, loaded by a host while the sequencer is idle.
- Issues instructions one at a time on the processor's INSTRin/run interface, keeps INSTRin stable until the processor's done, and advances a program counter.
- Detects a hung processor with a watchdog and supports host abort.

Parameters:
- ADDR_W, 4, program memory address width; depth = 2**ADDR_W words.
- INSTR_W, 16, instruction width; must match the processor's INSTRin.
- TIMEOUT, 8, maximum WAIT cycles without done_in before the ERROR state.

Ports:
- clk  in  1  clock; shared with the processor.
- reset  in  1  synchronous, active-high; shared with the processor.
- start  in  1  begin execution at address 0; honoured only in IDLE, HALT or ERROR.
- abort  in  1  return to IDLE from any state.
- prog_len  in  ADDR_W+1  number of instructions; latched when start is accepted.
- prog_we  in  1  program write enable; honoured only in IDLE, HALT or ERROR.
- prog_waddr  in  ADDR_W  program write address.
- prog_wdata  in  INSTR_W  program write data.
- done_in  in  1  processor done (combinational in the processor's final state).
- instr  out  INSTR_W  to processor INSTRin; registered.
- run  out  1  to processor run; one-cycle pulse per instruction.
- pc  out  ADDR_W  address of the current instruction.
- retired  out  ADDR_W+1  count of instructions completed since the last accepted start.
- busy  out  1  high in ISSUE and WAIT.
- halted  out  1  high in HALT.
- err  out  1  high in ERROR.

Behaviour:
- Reset values: state=IDLE, instr=0, run=0, pc=0, retired=0, busy=0, halted=0, err=0.
- Reset does not clear program memory; its contents are undefined until written.
- Memory write: when prog_we=1 and state is IDLE, HALT or ERROR, mem[prog_waddr] <= prog_wdata at the clock edge. prog_we is ignored in ISSUE and WAIT.
- States are IDLE, ISSUE, WAIT, HALT, ERROR; run, busy, halted and err are Moore outputs.
- IDLE/HALT/ERROR on start=1 with prog_len!=0: go to ISSUE; pc<=0, retired<=0, instr<=mem[0], latch prog_len.
- start with prog_len=0: go to HALT with retired=0 and no run pulse.
- ISSUE: run=1 for exactly one cycle. On that edge the processor leaves C0 and loads its IR. Next state is WAIT; clear the watchdog counter.
- WAIT: run=0; instr is held stable, because the processor decodes INSTRin directly every cycle.
- WAIT, done_in=1: retired<=retired+1.
  - If pc==prog_len-1: go to HALT; pc holds.
  - Else: pc<=pc+1, instr<=mem[pc+1], go to ISSUE. This is back-to-back issue; the processor is in C0 in that cycle.
- WAIT, done_in=0: watchdog increments. When it reaches TIMEOUT, go to ERROR; pc and instr hold for debug.
- Instruction latency: mv = 2 cycles (ISSUE + 1 WAIT); add/sub/mult = 4 cycles (ISSUE + 3 WAIT).
- HALT and ERROR: sticky until start, abort or reset.
- abort=1: go to IDLE next edge with run=0; pc, retired and instr hold.
  - If abort arrives in WAIT, the processor may still be mid-instruction. The host must pulse reset before the next start.
  - abort has priority over start and done_in in the same cycle.
- Simultaneous prog_we and start in IDLE: the write completes at that edge, and the instr load reads the pre-write contents of mem[0].
- pc never wraps: the last address is prog_len-1, and prog_len <= 2**ADDR_W is a host requirement.

Decomposition:
- Shared package proc_pkg holds:
  - the sequencer state enum seq_state_t;
  - opcode constants OP_MV=2'b00, OP_ADD=2'b01, OP_SUB=2'b10, OP_MULT=2'b11;
  - the bit positions of II, M, rX and rY, for benches and assemblers.
- Natural sub-module: prog_mem. It has one write port and one asynchronous read port, holds depth 2**ADDR_W, and has no reset.
- A top-level wrapper connects instr_sequencer to part2; the processor itself is not modified.

Test Plan:
- Load {16'h2005, 16'h6003, 16'h1000, 16'hE002}, prog_len=4, start → run pulses at cycle offsets 0, 2, 6, 8. HALT is entered 12 cycles after the first ISSUE, with retired=4, r0=16 and r1=8.
- Single mv, 16'h2FFF, prog_len=1 → one run pulse, HALT 2 cycles later, r0=16'hFFFF (sign-extended), retired=1.
- Tie done_in to 0 with TIMEOUT=8 → err=1 exactly 8 WAIT cycles after ISSUE; pc=0, instr=mem[0].
- Assert abort during the second WAIT cycle of an add → IDLE next cycle, run never reasserts, retired=0. Then reset and start again → the program completes normally.
- Assert prog_we with addr 0 / data 16'h2001 while busy → mem[0] is unchanged. Assert the same write in HALT and restart → r0=1.
- start with prog_len=0 → HALT immediately, no run pulse, retired=0. Assert reset mid-WAIT → all outputs return to their reset values next cycle.
